keypad_emulator: RTL
====================

// Module: keypad_emulator
// PURPOSE
//  Emulates a 4x4 matrix keypad: the responder end of the column-scan interface.
//  Accepts a key-press request (4-bit code) and drives active-low rows whenever the
//  keypad reader pulls the matching column low, for a programmed press/release time.
//  Used for hardware-in-loop self-test and closed-loop simulation of the keypad reader.
// PARAMETERS
//  PRESS_CYCLES    200000  cycles key contact is held closed (HOLD state), >=1
//  RELEASE_CYCLES  100000  cycles of guaranteed open contact after release (GAP), >=1
//  BOUNCE_CYCLES   2000    length of each bounce phase (only with KEYPAD_EMU_BOUNCE_EN), >=1
//  BOUNCE_TOGGLE   250     contact toggle period inside a bounce phase, >=1
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  key_code   in   4  key to press (same code map as the keypad reader)
//  key_valid  in   1  press request; held until accepted
//  key_ready  out  1  high only in IDLE; request accepted when key_valid & key_ready
//  columnas   in   4  column drive from the reader, active-low
//  filas      out  4  row lines to the reader, active-low, 4'b1111 = no key
//  busy       out  1  high in every state except IDLE
//  done       out  1  one-cycle pulse when a press/release sequence completes
// BEHAVIOUR
//  Reset (sync): state IDLE, filas=4'b1111, key_ready=1, busy=0, done=0, counters=0.
//  Code map (col,row) -> code; row0..row3 per column:
//   col0: 1,4,7,E  col1: 2,5,8,0  col2: 3,6,9,C  col3: A,B,D,F
//  On accept: key_code decoded to (tcol,trow) and latched; key_ready drops next cycle.
//  Internal 'contact' bit; filas registered each cycle:
//   filas <= (contact && !columnas[tcol]) ? ~(4'b0001<<trow) : 4'b1111.
//   Latency columnas->filas = 1 cycle. Non-one-hot columnas: only columnas[tcol] matters.
//  FSM (each timed state lasts exactly its parameter in cycles, down-counter):
//   IDLE       contact=0; accept -> BOUNCE_IN (macro) else HOLD.
//   BOUNCE_IN  contact starts 1, inverts every BOUNCE_TOGGLE cycles -> HOLD.
//   HOLD       contact=1 for PRESS_CYCLES -> BOUNCE_OUT (macro) else GAP.
//   BOUNCE_OUT contact starts 0, inverts every BOUNCE_TOGGLE cycles -> GAP.
//   GAP        contact=0 for RELEASE_CYCLES -> IDLE with done=1 that cycle.
//  done and key_ready are both high in the first IDLE cycle; a new request may be
//   accepted in that same cycle (back-to-back presses).
//  key_valid outside IDLE is ignored (no queueing); key_code changes after accept ignored.
//  Reset mid-operation: abort, IDLE next edge, filas=4'b1111, no done pulse.
//  Counter width $clog2(max parameter + 1); no wrap, reloads on every state entry.
// CONFIGURATION
//  KEYPAD_EMU_BOUNCE_EN defined: BOUNCE_IN/BOUNCE_OUT present, contact chatters at
//   both edges to exercise the reader's debouncers.
//  Not defined: bounce states and their counter removed; IDLE->HOLD->GAP->IDLE,
//   clean contact edges; BOUNCE_* parameters unused.
// TESTING (PRESS=40, RELEASE=20, BOUNCE=10, TOGGLE=3)
//  Reset asserted 2 cycles -> filas=1111, key_ready=1, busy=0, done=0.
//  No macro; code 5, columnas=1101 -> filas=1101 from 1 cycle after HOLD entry;
//   columnas=1110 -> filas=1111 next cycle.
//  No macro; code E, columnas=1110 -> filas=0111 for 40 cycles, 1111 in GAP,
//   done pulse exactly 60 cycles after HOLD entry; busy 0 same cycle.
//  key_valid with code 3 while busy -> ignored, key_ready=0; after done, code 3
//   accepted same cycle as done, columnas=1011 -> filas=1110.
//  Reset asserted mid-HOLD (code 8, columnas=1101) -> filas=1111 next cycle,
//   key_ready=1, done never pulses.
//  Macro on; code A, columnas=0111 held -> filas toggles 1110/1111 every 3 cycles
//   for 10 cycles, steady 1110 for 40, toggles 1111/1110 for 10, done after GAP.

Source files
------------

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad responder driving active-low rows on column scan
// Optional contact bounce at press/release edges: define KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator #(
    parameter int PRESS_CYCLES   = 200000,
    parameter int RELEASE_CYCLES = 100000,
    parameter int BOUNCE_CYCLES  = 2000,
    parameter int BOUNCE_TOGGLE  = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] columnas,
    output logic [3:0] filas,
    output logic       busy,
    output logic       done
);

    localparam int MAX_PR    = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int MAX_BT    = (BOUNCE_CYCLES > BOUNCE_TOGGLE) ? BOUNCE_CYCLES : BOUNCE_TOGGLE;
    localparam int MAX_TIMED = (MAX_PR > MAX_BT) ? MAX_PR : MAX_BT;
    localparam int CNT_W     = $clog2(MAX_TIMED + 1);

    localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES - 1);

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int TOG_W = $clog2(BOUNCE_TOGGLE + 1);
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [TOG_W-1:0] TOG_LOAD    = TOG_W'(BOUNCE_TOGGLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP
    } state_t;

    logic [TOG_W-1:0] tog_cnt;
    logic             bounce_contact;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_HOLD, S_GAP
    } state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       tcol;
    logic [1:0]       trow;
    logic             contact;

    // Returns {column, row} of the key in the reader's code map.
    function automatic logic [3:0] decode(input logic [3:0] code);
        case (code)
            4'h1: decode = {2'd0, 2'd0};
            4'h4: decode = {2'd0, 2'd1};
            4'h7: decode = {2'd0, 2'd2};
            4'hE: decode = {2'd0, 2'd3};
            4'h2: decode = {2'd1, 2'd0};
            4'h5: decode = {2'd1, 2'd1};
            4'h8: decode = {2'd1, 2'd2};
            4'h0: decode = {2'd1, 2'd3};
            4'h3: decode = {2'd2, 2'd0};
            4'h6: decode = {2'd2, 2'd1};
            4'h9: decode = {2'd2, 2'd2};
            4'hC: decode = {2'd2, 2'd3};
            4'hA: decode = {2'd3, 2'd0};
            4'hB: decode = {2'd3, 2'd1};
            4'hD: decode = {2'd3, 2'd2};
            default: decode = {2'd3, 2'd3};
        endcase
    endfunction

    always_comb begin
        contact = 1'b0;
        case (state)
            S_HOLD:       contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            S_BOUNCE_IN,
            S_BOUNCE_OUT: contact = bounce_contact;
`endif
            default:      contact = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tcol      <= '0;
            trow      <= '0;
            filas     <= 4'b1111;
            key_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            tog_cnt        <= '0;
            bounce_contact <= 1'b0;
`endif
        end else begin
            // Only the selected column matters, so non-one-hot scans are harmless.
            filas <= (contact && !columnas[tcol]) ? ~(4'b0001 << trow) : 4'b1111;
            done  <= 1'b0;

`ifdef KEYPAD_EMU_BOUNCE_EN
            if (state == S_BOUNCE_IN || state == S_BOUNCE_OUT) begin
                if (tog_cnt == '0) begin
                    bounce_contact <= ~bounce_contact;
                    tog_cnt        <= TOG_LOAD;
                end else begin
                    tog_cnt <= tog_cnt - TOG_W'(1);
                end
            end
`endif

            case (state)
                S_IDLE: begin
                    if (key_valid && key_ready) begin
                        {tcol, trow} <= decode(key_code);
                        key_ready    <= 1'b0;
                        busy         <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state          <= S_BOUNCE_IN;
                        cnt            <= BOUNCE_LOAD;
                        bounce_contact <= 1'b1;
                        tog_cnt        <= TOG_LOAD;
`else
                        state <= S_HOLD;
                        cnt   <= PRESS_LOAD;
`endif
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                S_BOUNCE_IN: begin
                    if (cnt == '0) begin
                        state <= S_HOLD;
                        cnt   <= PRESS_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif
                S_HOLD: begin
                    if (cnt == '0) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state          <= S_BOUNCE_OUT;
                        cnt            <= BOUNCE_LOAD;
                        bounce_contact <= 1'b0;
                        tog_cnt        <= TOG_LOAD;
`else
                        state <= S_GAP;
                        cnt   <= RELEASE_LOAD;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                S_BOUNCE_OUT: begin
                    if (cnt == '0) begin
                        state <= S_GAP;
                        cnt   <= RELEASE_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif
                S_GAP: begin
                    if (cnt == '0) begin
                        state     <= S_IDLE;
                        done      <= 1'b1;
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    key_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
